// File: rtl/stage_2.sv
// Decode stage: IF/ID pipeline register, 32x32 register file with write-through
// bypass, immediate generation and main control decode.
module stage_2 #(
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       Instruction_Fetch_IF_PM,
    input  logic [31:0]       PC_IF,
    input  logic              Do_Stall,
    input  logic              Is_Branch_Taken,
    input  logic              Reg_Write_WB,
    input  logic [4:0]        Rd_WB,
    input  logic [DATA_W-1:0] Write_Data_WB,
    output logic [31:0]       Instruction_Register_ID,
    output logic [31:0]       PC_ID,
    output logic [4:0]        Rs1_ID,
    output logic [4:0]        Rs2_ID,
    output logic [4:0]        Rd_ID,
    output logic [DATA_W-1:0] Rs1_Data_ID,
    output logic [DATA_W-1:0] Rs2_Data_ID,
    output logic [31:0]       Immediate_ID,
    output logic [2:0]        Funct3_ID,
    output logic [6:0]        Funct7_ID,
    output logic [6:0]        Opcode_ID,
    output logic              Reg_Write_ID,
    output logic              Mem_Read_ID,
    output logic              Mem_Write_ID,
    output logic              ALU_Src_ID,
    output logic              Branch_ID,
    output logic              Jump_ID,
    output logic              Illegal_ID
);

    localparam logic [31:0] NOP      = 32'h0000_0033;
    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_BR    = 7'b1100011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins);
        logic signed [31:0] imm;
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm = 32'($signed(ins[31:20]));
            OP_STORE: imm = 32'($signed({ins[31:25], ins[11:7]}));
            OP_BR:    imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            OP_LUI, OP_AUIPC: imm = $signed({ins[31:12], 12'b0});
            OP_JAL:   imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:  imm = '0;
        endcase
        return imm;
    endfunction

    logic [31:0]       instr_p1;
    logic [31:0]       pc_p1;
    logic [DATA_W-1:0] regs [0:31];
    logic              rw_raw;

    // IF -> ID boundary: flush beats stall; a flush leaves the PC untouched
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            instr_p1 <= NOP;
            pc_p1    <= '0;
        end else if (Is_Branch_Taken) begin
            instr_p1 <= NOP;
        end else if (!Do_Stall) begin
            instr_p1 <= Instruction_Fetch_IF_PM;
            pc_p1    <= PC_IF;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (Reg_Write_WB && Rd_WB != 5'd0) begin
            regs[Rd_WB] <= Write_Data_WB;
        end
    end

    assign Instruction_Register_ID = instr_p1;
    assign PC_ID     = pc_p1;
    assign Rs1_ID    = instr_p1[19:15];
    assign Rs2_ID    = instr_p1[24:20];
    assign Rd_ID     = instr_p1[11:7];
    assign Funct3_ID = instr_p1[14:12];
    assign Funct7_ID = instr_p1[31:25];
    assign Opcode_ID = instr_p1[6:0];
    assign Immediate_ID = imm_gen(instr_p1);

    // Same-cycle writeback is forwarded so ID never sees a stale operand
    always_comb begin
        Rs1_Data_ID = regs[Rs1_ID];
        Rs2_Data_ID = regs[Rs2_ID];
        if (Reg_Write_WB && Rd_WB != 5'd0 && Rd_WB == Rs1_ID) Rs1_Data_ID = Write_Data_WB;
        if (Reg_Write_WB && Rd_WB != 5'd0 && Rd_WB == Rs2_ID) Rs2_Data_ID = Write_Data_WB;
        if (Rs1_ID == 5'd0) Rs1_Data_ID = '0;
        if (Rs2_ID == 5'd0) Rs2_Data_ID = '0;
    end

    always_comb begin
        rw_raw       = 1'b0;
        Mem_Read_ID  = 1'b0;
        Mem_Write_ID = 1'b0;
        ALU_Src_ID   = 1'b0;
        Branch_ID    = 1'b0;
        Jump_ID      = 1'b0;
        Illegal_ID   = 1'b0;
        case (Opcode_ID)
            OP_R:     rw_raw = 1'b1;
            OP_IMM:   begin rw_raw = 1'b1; ALU_Src_ID = 1'b1; end
            OP_LOAD:  begin rw_raw = 1'b1; ALU_Src_ID = 1'b1; Mem_Read_ID = 1'b1; end
            OP_STORE: begin ALU_Src_ID = 1'b1; Mem_Write_ID = 1'b1; end
            OP_BR:    Branch_ID = 1'b1;
            OP_JAL:   begin rw_raw = 1'b1; Jump_ID = 1'b1; end
            OP_JALR:  begin rw_raw = 1'b1; Jump_ID = 1'b1; ALU_Src_ID = 1'b1; end
            OP_LUI, OP_AUIPC: begin rw_raw = 1'b1; ALU_Src_ID = 1'b1; end
            default:  Illegal_ID = 1'b1;
        endcase
    end

    assign Reg_Write_ID = rw_raw && (Rd_ID != 5'd0);

endmodule

// File: doc/stage_2.md
STAGE_2 -- requirements
Module: stage_2

Interface
REQ-001 Clock  input  1  single clock; all state updates on posedge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 Instruction_Fetch_IF_PM  input  32  instruction delivered by fetch stage (after fetch NOP/freeze mux).
REQ-004 PC_IF  input  32  PC of the instruction on Instruction_Fetch_IF_PM.
REQ-005 Do_Stall  input  1  from pipeline management; hold IF/ID register.
REQ-006 Is_Branch_Taken  input  1  from pipeline management; flush IF/ID register.
REQ-007 Reg_Write_WB  input  1  writeback enable.
REQ-008 Rd_WB  input  5  writeback destination register.
REQ-009 Write_Data_WB  input  32  writeback data.
REQ-010 Instruction_Register_ID  output  32  current IF/ID instruction; fed back to fetch freeze path.
REQ-011 PC_ID  output  32  PC of instruction in ID.
REQ-012 Rs1_ID, Rs2_ID, Rd_ID  output  5 each  register fields [19:15], [24:20], [11:7].
REQ-013 Rs1_Data_ID, Rs2_Data_ID  output  32 each  register file read data.
REQ-014 Immediate_ID  output  32  sign-extended immediate.
REQ-015 Funct3_ID  output  3; Funct7_ID  output  7; Opcode_ID  output  7  raw fields.
REQ-016 Reg_Write_ID, Mem_Read_ID, Mem_Write_ID, ALU_Src_ID, Branch_ID, Jump_ID, Illegal_ID  output  1 each  decoded controls.

Function
REQ-017 IF/ID register (instruction 32b, PC 32b) SHALL update on posedge Clock with priority: Is_Branch_Taken -> load NOP 0x00000033, PC unchanged; else Do_Stall -> hold; else load Instruction_Fetch_IF_PM and PC_IF.
REQ-018 Is_Branch_Taken and Do_Stall both high SHALL flush (flush wins).
REQ-019 Register file: 32 x 32b, written on posedge Clock when Reg_Write_WB=1 and Rd_WB!=0; writes independent of Do_Stall/flush.
REQ-020 x0 SHALL always read 0; writes to x0 discarded.
REQ-021 Reads combinational from Rs1_ID/Rs2_ID; when Reg_Write_WB=1, Rd_WB!=0 and Rd_WB equals a read index, that port SHALL return Write_Data_WB in the same cycle (write-through bypass).
REQ-022 Immediate by opcode: I (0000011, 0010011, 1100111) = sext[31:20]; S (0100011) = sext{[31:25],[11:7]}; B (1100011) = sext{[31],[7],[30:25],[11:8],0}; U (0110111, 0010111) = {[31:12],12'b0}; J (1101111) = sext{[31],[19:12],[20],[30:21],0}; R and others = 0.
REQ-023 Controls: R 0110011 -> Reg_Write; I-ALU 0010011 -> Reg_Write, ALU_Src; load -> Reg_Write, ALU_Src, Mem_Read; store -> ALU_Src, Mem_Write; branch -> Branch; JAL/JALR -> Reg_Write, Jump (JALR also ALU_Src); LUI/AUIPC -> Reg_Write, ALU_Src.
REQ-024 Reg_Write_ID SHALL be 0 when Rd_ID=0.
REQ-025 Unlisted opcode -> all controls 0, Illegal_ID=1.
REQ-026 All decode outputs combinational from IF/ID register only (1-cycle latency from fetch input).

Reset
REQ-027 Reset low SHALL immediately force instruction register 0x00000033, PC_ID 0, all 32 registers 0, independent of Clock.
REQ-028 During reset, outputs: Rd/Rs fields 0, data 0, Immediate 0, Reg_Write_ID 0 (Rd=0), other controls 0, Illegal_ID 0.
REQ-029 Reset asserted mid-operation SHALL discard pending writeback in that cycle; first capture on first posedge after deassertion.

Verification
REQ-030 Load 0x00300093 (addi x1,x0,3) at PC 0x10, no stall -> next cycle PC_ID=0x10, Rd_ID=1, Immediate_ID=3, Reg_Write_ID=1, ALU_Src_ID=1.
REQ-031 Do_Stall=1 for 3 cycles with changing input -> Instruction_Register_ID/PC_ID unchanged; then Is_Branch_Taken=1 with Do_Stall=1 -> 0x00000033.
REQ-032 Write x5=0xDEADBEEF while ID holds add x1,x5,x5 -> Rs1_Data_ID=Rs2_Data_ID=0xDEADBEEF same cycle (bypass), and after.
REQ-033 Write x0=0xFFFFFFFF -> x0 reads 0; beq 0xFE528AE3 -> Immediate_ID=0xFFFFFFF4, Branch_ID=1.
REQ-034 Opcode 1111111 -> Illegal_ID=1, controls 0; Reset pulse low mid-cycle -> instantly NOP, PC_ID 0, registers 0.
